// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
// Imported by the PC generator and the top-level sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] ECALL_INSN    = 32'h0000_0073;
  localparam int unsigned DEFAULT_DEPTH = 256;

  // A fetch address is usable only if word aligned and inside the memory.
  function automatic logic pc_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-PC selection and target range checking.
// pc_fault flags that the PC about to be taken is misaligned or out of range.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic        pc_fault
);

  logic [31:0] pc_inc;

  assign pc_inc = pc + 32'd4;

  // Redirect beats the sequential increment; only the chosen target is checked.
  always_comb begin
    pc_fault = 1'b0;
    if (redirect) begin
      pc_fault = !pc_in_range(redirect_pc, DEPTH);
    end else if (advance) begin
      pc_fault = !pc_in_range(pc_inc, DEPTH);
    end
  end

  // A faulting target is never loaded, so pc keeps the last legal address.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load_start) begin
      pc <= RESET_PC;
    end else if (pc_fault) begin
      pc <= pc;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Sequencer and arbiter for a word-addressed, combinational-read instruction memory.
// Owns the PC, streams instructions to decode, and lends the memory port to a loader.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ECALL    = ECALL_INSN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_req,
  output logic        load_gnt,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  // Handshake: instr/instr_pc are offered while instr_valid is high and transfer
  // on any edge where instr_valid && instr_ready; without a transfer or redirect
  // they stay stable.

  fetch_state_t state;
  fetch_state_t next_state;

  logic [31:0] pc;
  logic        pc_fault;
  logic        running;
  logic        accept;
  logic        is_ecall;
  logic        take_redirect;
  logic        advance;
  logic        start_run;

  assign running       = (state == RUN);
  assign accept        = running && instr_ready;
  assign is_ecall      = (imem_rdata == ECALL);
  assign take_redirect = running && redirect_valid && !(accept && is_ecall);
  assign advance       = accept && !is_ecall;
  assign start_run     = ((state == IDLE) || (state == HALT)) && (next_state == RUN);

  fetch_pc_gen #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .reset      (reset),
    .load_start (start_run),
    .redirect   (take_redirect),
    .redirect_pc(redirect_pc),
    .advance    (advance),
    .pc         (pc),
    .pc_fault   (pc_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Loader requests win over start; a running core is never preempted.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_req) next_state = LOAD;
        else if (start) next_state = RUN;
      end
      LOAD: begin
        if (!load_req) next_state = IDLE;
      end
      RUN: begin
        if (accept && is_ecall) next_state = HALT;
        else if (pc_fault) next_state = HALT;
      end
      HALT: begin
        if (load_req) next_state = LOAD;
        else if (start) next_state = RUN;
      end
      default: next_state = IDLE;
    endcase
  end

  // A write strobe coinciding with reset is dropped so reset wins cleanly.
  always_comb begin
    load_gnt    = (state == LOAD);
    halted      = (state == HALT);
    instr_valid = running;
    instr       = 32'h0;
    instr_pc    = 32'h0;
    imem_addr   = pc;
    imem_we     = 1'b0;
    imem_wdata  = 32'h0;
    if (state == LOAD) begin
      imem_addr  = load_addr;
      imem_we    = load_we && !reset;
      imem_wdata = load_data;
    end
    if (running) begin
      instr    = imem_rdata;
      instr_pc = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (start_run && (state == HALT)) begin
      fault <= 1'b0;
    end else if (running && pc_fault) begin
      fault <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
    end else if (start_run && (state == HALT)) begin
      fetch_count <= 32'h0;
    end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a behavioural 256-word memory.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        load_req;
  logic        load_gnt;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];

  int n_checks;
  int n_fail;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h402082B3;
  localparam logic [31:0] I1  = 32'h00208133;
  localparam logic [31:0] I2  = 32'h00000073;

  imem_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .load_req      (load_req),
    .load_gnt      (load_gnt),
    .load_we       (load_we),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .imem_addr     (imem_addr),
    .imem_we       (imem_we),
    .imem_wdata    (imem_wdata),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted),
    .fault         (fault),
    .fetch_count   (fetch_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, synchronous write
  assign imem_rdata = mem[imem_addr[9:2]];
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr[9:2]] <= imem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_words(input logic [31:0] base, input int count);
    load_req = 1'b1;
    settle();
    step();
    check("load_gnt", {31'b0, load_gnt}, 32'd1);
    for (int i = 0; i < count; i++) begin
      load_we   = 1'b1;
      load_addr = base + 32'(i * 4);
      load_data = exp_q.pop_front();
      settle();
      check("load_imem_we", {31'b0, imem_we}, 32'd1);
      check("load_imem_addr", imem_addr, load_addr);
      step();
    end
    load_we  = 1'b0;
    load_req = 1'b0;
    settle();
    step();
    check("load_release", {31'b0, load_gnt}, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    settle();
    step();
    start = 1'b0;
    settle();
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] ins, input logic [31:0] pcv);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, ins);
    check({tag, "_pc"}, instr_pc, pcv);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    reset = 1'b1; start = 1'b0; load_req = 1'b0; load_we = 1'b0;
    load_addr = 32'h0; load_data = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    reset = 1'b0;
    settle();
    step();

    // reset state
    check("rst_load_gnt", {31'b0, load_gnt}, 32'd0);
    check("rst_imem_we", {31'b0, imem_we}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);

    // test 1: load program and run to ECALL
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    exp_q.push_back(I2);
    load_words(32'h0, 3);
    check("mem0", mem[0], I0);
    check("mem2", mem[2], I2);
    do_start();
    instr_ready = 1'b1;
    settle();
    expect_fetch("t1_a", I0, 32'h0);
    step();
    expect_fetch("t1_b", I1, 32'h4);
    step();
    expect_fetch("t1_c", I2, 32'h8);
    step();
    check("t1_halted", {31'b0, halted}, 32'd1);
    check("t1_valid", {31'b0, instr_valid}, 32'd0);
    check("t1_count", fetch_count, 32'd3);
    check("t1_fault", {31'b0, fault}, 32'd0);

    // test 2: back-pressure at pc 0x4
    instr_ready = 1'b0;
    do_start();
    check("t2_count_clr", fetch_count, 32'd0);
    instr_ready = 1'b1;
    settle();
    step();
    instr_ready = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      expect_fetch("t2_hold", I1, 32'h4);
      check("t2_hold_count", fetch_count, 32'd1);
      step();
    end
    instr_ready = 1'b1;
    settle();
    step();
    step();
    check("t2_halted", {31'b0, halted}, 32'd1);
    check("t2_count", fetch_count, 32'd3);

    // test 3: redirects, with and without accept, and ECALL over redirect
    instr_ready = 1'b0;
    do_start();
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
    settle();
    step();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    settle();
    expect_fetch("t3_redir", NOP, 32'h10);
    check("t3_count", fetch_count, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    settle();
    step();
    redirect_valid = 1'b0;
    settle();
    expect_fetch("t3_noacc", I0, 32'h0);
    check("t3_noacc_count", fetch_count, 32'd1);
    instr_ready = 1'b1;
    settle();
    step();
    step();
    expect_fetch("t3_at_ecall", I2, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    settle();
    step();
    redirect_valid = 1'b0;
    settle();
    check("t3_ecall_halt", {31'b0, halted}, 32'd1);
    check("t3_ecall_fault", {31'b0, fault}, 32'd0);
    check("t3_ecall_count", fetch_count, 32'd4);

    // test 4: misaligned, out-of-range redirect, sequential overflow
    instr_ready = 1'b0;
    do_start();
    redirect_valid = 1'b1; redirect_pc = 32'h402;
    settle();
    step();
    redirect_valid = 1'b0;
    settle();
    check("t4a_halted", {31'b0, halted}, 32'd1);
    check("t4a_fault", {31'b0, fault}, 32'd1);
    do_start();
    check("t4b_fault_clr", {31'b0, fault}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    settle();
    step();
    redirect_valid = 1'b0;
    settle();
    check("t4b_halted", {31'b0, halted}, 32'd1);
    check("t4b_fault", {31'b0, fault}, 32'd1);
    do_start();
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    settle();
    step();
    redirect_valid = 1'b0;
    settle();
    expect_fetch("t4c_last", NOP, 32'h3FC);
    check("t4c_not_halted", {31'b0, halted}, 32'd0);
    instr_ready = 1'b1;
    settle();
    step();
    check("t4c_halted", {31'b0, halted}, 32'd1);
    check("t4c_fault", {31'b0, fault}, 32'd1);
    check("t4c_count", fetch_count, 32'd1);

    // test 5: loader ignored while running
    instr_ready = 1'b0;
    do_start();
    load_req = 1'b1; load_we = 1'b1; load_addr = 32'h0; load_data = 32'h0;
    settle();
    check("t5_gnt", {31'b0, load_gnt}, 32'd0);
    check("t5_we", {31'b0, imem_we}, 32'd0);
    step();
    load_req = 1'b0; load_we = 1'b0;
    settle();
    check("t5_mem0", mem[0], I0);
    expect_fetch("t5_run", I0, 32'h0);

    // test 6: reset mid-RUN at pc 0x8, then restart
    instr_ready = 1'b1;
    settle();
    step();
    step();
    instr_ready = 1'b0;
    settle();
    expect_fetch("t6_at8", I2, 32'h8);
    reset = 1'b1;
    settle();
    step();
    reset = 1'b0;
    settle();
    check("t6_valid", {31'b0, instr_valid}, 32'd0);
    check("t6_count", fetch_count, 32'd0);
    check("t6_halted", {31'b0, halted}, 32'd0);
    do_start();
    expect_fetch("t6_restart", I0, 32'h0);

    // reset coinciding with a loader write drops the write
    reset = 1'b1;
    settle();
    step();
    reset = 1'b0;
    load_req = 1'b1;
    settle();
    step();
    load_we = 1'b1; load_addr = 32'h0; load_data = 32'hDEAD_BEEF; reset = 1'b1;
    settle();
    step();
    reset = 1'b0; load_we = 1'b0; load_req = 1'b0;
    settle();
    check("t7_gnt", {31'b0, load_gnt}, 32'd0);
    check("t7_mem0", mem[0], I0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
